calc_sequencer: RTL and testbench

- Sequences the calculator datapath from decoded keypad events: digit entry, operator, equals, backspace, clear entry and clear all.
- Sits directly downstream of the keypad interpreter. Its outputs drive the hex display driver.
- Holds an entry register, an accumulator and a pending operator.
- Evaluates strictly left-to-right: add and subtract take one cycle; multiply uses an iterative shift-add unit.

---
 rtl/calc_defs.sv | 24 ++
 rtl/calc_mult_seq.sv | 58 +++++
 rtl/calc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/calc_defs.sv
// Shared definitions for the calculator sequencer: opcodes, FSM states,
// pending-operator encoding and default datapath width.
package calc_defs;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {ST_ENTRY, ST_OPWAIT, ST_RESULT, ST_MUL} state_t;

  // PD_NONE means no operator is waiting for its second operand
  typedef enum logic [1:0] {PD_NONE, PD_ADD, PD_MUL, PD_SUB} pend_t;

  function automatic pend_t op2pend(input logic [1:0] op);
    case (op)
      OP_MUL:  return PD_MUL;
      OP_SUB:  return PD_SUB;
      default: return PD_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_mult_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, the first bit
// consumed on the start edge, done after WIDTH cycles; abort cancels a run.
module calc_mult_seq
  import calc_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic              active;
  logic [CW-1:0]     cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]  mplier;

  assign done = active && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (abort) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(1);
    end else if (done) begin
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Operand/product registers carry no reset; they are only read on done
  always_ff @(posedge clock) begin
    if (start && !abort) begin
      mcand   <= {{WIDTH{1'b0}}, a} << 1;
      mplier  <= b >> 1;
      product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
    end else if (active && !done) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: entry register, accumulator and pending operator,
// evaluated left-to-right. Define CALC_OVERFLOW_EN for the sticky ovf flag.
module calc_sequencer
  import calc_defs::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             newhex,
  input  logic [3:0]       hexcode,
  input  logic             newop,
  input  logic [1:0]       opcode,
  input  logic             eq,
  input  logic             BS,
  input  logic             CA,
  input  logic             CE,
  output logic [WIDTH-1:0] display,
  output logic             busy,
  output logic             ovf
);

  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [NW-1:0] MAXCNT = NW'(DIGITS);

  state_t           state, n_state;
  pend_t            pend, n_pend;
  logic [WIDTH-1:0] entry, n_entry;
  logic [WIDTH-1:0] acc, n_acc;
  logic [NW-1:0]    count, n_count;
  logic             mul_to_eq, n_mul_to_eq;
  logic             do_eval;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] opnd;
  logic [2*WIDTH-1:0] mul_prod;

  function automatic logic [WIDTH-1:0] alu(input pend_t p, input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    return (p == PD_SUB) ? x - y : x + y;
  endfunction

  // After an operator the second operand defaults to the accumulator itself
  assign opnd = (state == ST_OPWAIT) ? acc : entry;

  calc_mult_seq #(.WIDTH(WIDTH)) u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .abort   (CA),
    .a       (acc),
    .b       (opnd),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    n_state     = state;
    n_pend      = pend;
    n_entry     = entry;
    n_acc       = acc;
    n_count     = count;
    n_mul_to_eq = mul_to_eq;
    do_eval     = 1'b0;
    mul_start   = 1'b0;

    case (state)
      ST_ENTRY: begin
        if (CE) begin
          n_entry = '0;
          n_count = '0;
        end else if (BS) begin
          if (count != '0) begin
            n_entry = entry >> 4;
            n_count = count - NW'(1);
          end
        end else if (eq || newop) begin
          do_eval = 1'b1;
        end else if (newhex && count != MAXCNT) begin
          n_entry = {entry[WIDTH-5:0], hexcode};
          n_count = count + NW'(1);
        end
      end
      ST_OPWAIT: begin
        if (!(CE || BS)) begin
          if (eq) begin
            do_eval = 1'b1;
          end else if (newop) begin
            n_pend = op2pend(opcode);
          end else if (newhex) begin
            n_entry = {{(WIDTH-4){1'b0}}, hexcode};
            n_count = NW'(1);
            n_state = ST_ENTRY;
          end
        end
      end
      ST_RESULT: begin
        if (!(CE || BS || eq)) begin
          if (newop) begin
            n_pend  = op2pend(opcode);
            n_state = ST_OPWAIT;
          end else if (newhex) begin
            n_pend  = PD_NONE;
            n_entry = {{(WIDTH-4){1'b0}}, hexcode};
            n_count = NW'(1);
            n_state = ST_ENTRY;
          end
        end
      end
      default: begin
        if (mul_done) begin
          n_acc   = mul_prod[WIDTH-1:0];
          n_state = mul_to_eq ? ST_RESULT : ST_OPWAIT;
        end
      end
    endcase

    if (do_eval) begin
      if (pend == PD_MUL) begin
        mul_start   = 1'b1;
        n_mul_to_eq = eq;
        n_state     = ST_MUL;
      end else begin
        n_acc   = (pend == PD_NONE) ? opnd : alu(pend, acc, opnd);
        n_state = eq ? ST_RESULT : ST_OPWAIT;
      end
      n_pend = eq ? PD_NONE : op2pend(opcode);
    end

    if (CA) begin
      n_state     = ST_ENTRY;
      n_pend      = PD_NONE;
      n_entry     = '0;
      n_acc       = '0;
      n_count     = '0;
      n_mul_to_eq = 1'b0;
      mul_start   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_ENTRY;
      pend      <= PD_NONE;
      entry     <= '0;
      acc       <= '0;
      count     <= '0;
      mul_to_eq <= 1'b0;
      display   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= n_state;
      pend      <= n_pend;
      entry     <= n_entry;
      acc       <= n_acc;
      count     <= n_count;
      mul_to_eq <= n_mul_to_eq;
      display   <= (n_state == ST_ENTRY) ? n_entry : n_acc;
      busy      <= (n_state == ST_MUL);
    end
  end

`ifdef CALC_OVERFLOW_EN
  logic ovf_set;

  function automatic logic alu_ovf(input pend_t p, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
    return (p == PD_SUB) ? (x < y) : ((x + y) < x);
  endfunction

  always_comb begin
    ovf_set = 1'b0;
    if (do_eval && (pend == PD_ADD || pend == PD_SUB))
      ovf_set = alu_ovf(pend, acc, opnd);
    if (state == ST_MUL && mul_done)
      ovf_set = |mul_prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        ovf <= 1'b0;
    else if (CA)      ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
  end
`else
  logic unused_prod_hi;
  assign unused_prod_hi = ^mul_prod[2*WIDTH-1:WIDTH];
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (WIDTH=16) with a scoreboard of expected
// display/busy/ovf values pushed per stimulus step.
module tb_calc_sequencer;

  localparam int K_HEX = 0, K_OP = 1, K_EQ = 2, K_BS = 3, K_CE = 4, K_CA = 5, K_NONE = 6;
`ifdef CALC_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        newhex = 1'b0, newop = 1'b0, eq = 1'b0, BS = 1'b0, CA = 1'b0, CE = 1'b0;
  logic [3:0]  hexcode = 4'h0;
  logic [1:0]  opcode = 2'b00;
  logic [15:0] display;
  logic        busy, ovf;

  typedef struct {
    logic [15:0] d;
    logic        b;
    logic        o;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   ncyc;

  calc_sequencer #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .newhex  (newhex),
    .hexcode (hexcode),
    .newop   (newop),
    .opcode  (opcode),
    .eq      (eq),
    .BS      (BS),
    .CA      (CA),
    .CE      (CE),
    .display (display),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic press(input int kind, input logic [3:0] v, input logic [15:0] ed,
                       input logic eb, input logic eo, input string tag);
    exp_t e;
    sb.push_back('{ed, eb, eo, tag});
    case (kind)
      K_HEX:   begin newhex = 1'b1; hexcode = v; end
      K_OP:    begin newop = 1'b1; opcode = v[1:0]; end
      K_EQ:    eq = 1'b1;
      K_BS:    BS = 1'b1;
      K_CE:    CE = 1'b1;
      K_CA:    CA = 1'b1;
      default: ;
    endcase
    @(negedge clock);
    {newhex, newop, eq, BS, CE, CA} = '0;
    e = sb.pop_front();
    chk({e.tag, "_display"}, {16'h0, display}, {16'h0, e.d});
    chk({e.tag, "_busy"}, {31'h0, busy}, {31'h0, e.b});
    chk({e.tag, "_ovf"}, {31'h0, ovf}, {31'h0, e.o});
  endtask

  // Count negedges with busy high (the first was already seen); optional digit injection
  task automatic run_mul(input int inject_at, output int cnt);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == inject_at) begin
        newhex = 1'b1;
        hexcode = 4'h9;
      end
      @(negedge clock);
      newhex = 1'b0;
      if (busy) cnt++;
      else break;
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    press(K_NONE, 4'h0, 16'h0000, 1'b0, 1'b0, "reset");

    press(K_HEX, 4'h1, 16'h0001, 1'b0, 1'b0, "d1");
    press(K_HEX, 4'h2, 16'h0012, 1'b0, 1'b0, "d12");
    press(K_OP,  4'h0, 16'h0012, 1'b0, 1'b0, "add_op");
    press(K_HEX, 4'h3, 16'h0003, 1'b0, 1'b0, "d3");
    press(K_HEX, 4'h4, 16'h0034, 1'b0, 1'b0, "d34");
    press(K_EQ,  4'h0, 16'h0046, 1'b0, 1'b0, "sum");
    press(K_HEX, 4'h7, 16'h0007, 1'b0, 1'b0, "newcalc");
    press(K_EQ,  4'h0, 16'h0007, 1'b0, 1'b0, "pend_clr");

    press(K_CA,  4'h0, 16'h0000, 1'b0, 1'b0, "ca1");
    press(K_HEX, 4'h5, 16'h0005, 1'b0, 1'b0, "d5");
    press(K_OP,  4'h2, 16'h0005, 1'b0, 1'b0, "sub_op");
    press(K_HEX, 4'h7, 16'h0007, 1'b0, 1'b0, "d7");
    press(K_EQ,  4'h0, 16'hFFFE, 1'b0, OVF,  "sub_wrap");
    press(K_CA,  4'h0, 16'h0000, 1'b0, 1'b0, "ca_ovf");

    press(K_HEX, 4'h1, 16'h0001, 1'b0, 1'b0, "m1");
    press(K_HEX, 4'h2, 16'h0012, 1'b0, 1'b0, "m12");
    press(K_OP,  4'h1, 16'h0012, 1'b0, 1'b0, "mul_op");
    press(K_HEX, 4'h1, 16'h0001, 1'b0, 1'b0, "m1b");
    press(K_HEX, 4'h0, 16'h0010, 1'b0, 1'b0, "m10");
    press(K_EQ,  4'h0, 16'h0012, 1'b1, 1'b0, "mul_start");
    run_mul(4, ncyc);
    chk("mul_busy_cycles", ncyc, 16);
    chk("mul_product", {16'h0, display}, 32'h0120);
    chk("mul_busy_low", {31'h0, busy}, 32'h0);
    press(K_NONE, 4'h0, 16'h0120, 1'b0, 1'b0, "mul_hold");

    press(K_CA,  4'h0, 16'h0000, 1'b0, 1'b0, "ca2");
    press(K_HEX, 4'h2, 16'h0002, 1'b0, 1'b0, "l2");
    press(K_OP,  4'h0, 16'h0002, 1'b0, 1'b0, "l_add");
    press(K_HEX, 4'h3, 16'h0003, 1'b0, 1'b0, "l3");
    press(K_OP,  4'h1, 16'h0005, 1'b0, 1'b0, "l2r_partial");
    press(K_HEX, 4'h4, 16'h0004, 1'b0, 1'b0, "l4");
    press(K_EQ,  4'h0, 16'h0005, 1'b1, 1'b0, "l_mul_start");
    run_mul(-1, ncyc);
    chk("l_busy_cycles", ncyc, 16);
    chk("l2r_result", {16'h0, display}, 32'h0014);

    press(K_CA,  4'h0, 16'h0000, 1'b0, 1'b0, "ca3");
    press(K_HEX, 4'h3, 16'h0003, 1'b0, 1'b0, "a3");
    press(K_OP,  4'h0, 16'h0003, 1'b0, 1'b0, "a_add");
    press(K_HEX, 4'h1, 16'h0001, 1'b0, 1'b0, "e1");
    press(K_HEX, 4'h2, 16'h0012, 1'b0, 1'b0, "e12");
    press(K_HEX, 4'h3, 16'h0123, 1'b0, 1'b0, "e123");
    press(K_HEX, 4'h4, 16'h1234, 1'b0, 1'b0, "e1234");
    press(K_HEX, 4'h5, 16'h1234, 1'b0, 1'b0, "digit_cap");
    press(K_BS,  4'h0, 16'h0123, 1'b0, 1'b0, "backspace");
    press(K_CE,  4'h0, 16'h0000, 1'b0, 1'b0, "clear_entry");
    press(K_EQ,  4'h0, 16'h0003, 1'b0, 1'b0, "acc_intact");

    press(K_CA,  4'h0, 16'h0000, 1'b0, 1'b0, "ca4");
    press(K_HEX, 4'h2, 16'h0002, 1'b0, 1'b0, "x2");
    press(K_OP,  4'h1, 16'h0002, 1'b0, 1'b0, "x_mul");
    press(K_HEX, 4'h3, 16'h0003, 1'b0, 1'b0, "x3");
    press(K_EQ,  4'h0, 16'h0002, 1'b1, 1'b0, "x_start");
    press(K_NONE, 4'h0, 16'h0002, 1'b1, 1'b0, "x_run1");
    press(K_NONE, 4'h0, 16'h0002, 1'b1, 1'b0, "x_run2");
    press(K_CA,  4'h0, 16'h0000, 1'b0, 1'b0, "ca_abort");
    press(K_HEX, 4'h5, 16'h0005, 1'b0, 1'b0, "post_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
